captura_numero: RTL and testbench

//  Keypad-side initiator for the 4-digit BCD accumulator adder. Assembles a BCD

---
 rtl/captura_numero_if.sv | 26 ++
 rtl/captura_numero.sv | 144 ++++++++++++++
 tb/tb_captura_numero.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/captura_numero_if.sv
// Keypad/adder side signals of captura_numero grouped as one bundle.
// master: the operand capture block; slave: keypad decoder plus BCD adder.
interface captura_numero_if #(
    parameter int unsigned DIGITS = 4
);
    logic                   tecla_valid;
    logic [3:0]             tecla;
    logic                   ent;
    logic                   rst_sv;
    logic [DIGITS-1:0][3:0] numero;
    logic                   suma;
    logic                   guardar;
    logic [2:0]             cuenta;
    logic                   ocupado;
    logic                   error;

    modport master (
        input  tecla_valid, tecla, ent, rst_sv,
        output numero, suma, guardar, cuenta, ocupado, error
    );

    modport slave (
        output tecla_valid, tecla, ent, rst_sv,
        input  numero, suma, guardar, cuenta, ocupado, error
    );
endinterface

// File: rtl/captura_numero.sv
// Keypad-side initiator for the BCD accumulator adder: builds a BCD operand
// from digit strobes, requests sums and saves, and waits for the adder's
// acknowledges with a timeout.
module captura_numero #(
    parameter int unsigned DIGITS   = 4,
    parameter logic [3:0]  KEY_SUM  = 4'hA,
    parameter logic [3:0]  KEY_SAVE = 4'hB,
    parameter logic [3:0]  KEY_CLR  = 4'hC,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    captura_numero_if.master bus
);

    localparam int unsigned TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]  CUENTA_MAX = 3'(DIGITS);

    typedef enum logic [2:0] {
        StEntry,
        StSumReq,
        StWaitEnt,
        StResult,
        StSaveReq
    } state_t;

    state_t                 state_q, state_d;
    logic [DIGITS-1:0][3:0] numero_q, numero_d;
    logic [2:0]             cuenta_q, cuenta_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   suma_q, suma_d;
    logic                   guardar_q, guardar_d;
    logic                   ocupado_q, ocupado_d;
    logic                   error_q, error_d;

    // Next-state and next-output decode; every output is registered.
    always_comb begin
        state_d   = state_q;
        numero_d  = numero_q;
        cuenta_d  = cuenta_q;
        timer_d   = timer_q;
        error_d   = error_q;
        suma_d    = 1'b0;
        guardar_d = 1'b0;

        unique case (state_q)
            // RESULT accepts keys exactly like ENTRY; a digit returns to ENTRY.
            StEntry, StResult: begin
                timer_d = '0;
                if (bus.tecla_valid) begin
                    if (bus.tecla <= 4'd9) begin
                        if (cuenta_q < CUENTA_MAX) begin
                            for (int i = DIGITS - 1; i > 0; i--) begin
                                numero_d[i] = numero_q[i-1];
                            end
                            numero_d[0] = bus.tecla;
                            cuenta_d    = cuenta_q + 3'd1;
                            state_d     = StEntry;
                        end
                    end else if (bus.tecla == KEY_CLR) begin
                        numero_d = '0;
                        cuenta_d = '0;
                        error_d  = 1'b0;
                    end else if (bus.tecla == KEY_SUM) begin
                        if (cuenta_q != 3'd0) begin
                            state_d = StSumReq;
                            suma_d  = 1'b1;
                        end
                    end else if (bus.tecla == KEY_SAVE) begin
                        state_d   = StSaveReq;
                        guardar_d = 1'b1;
                    end
                end
            end
            // suma is high during this single cycle; ent is not looked at yet.
            StSumReq: begin
                state_d = StWaitEnt;
                timer_d = '0;
            end
            StWaitEnt: begin
                if (bus.ent) begin
                    state_d  = StResult;
                    numero_d = '0;
                    cuenta_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = StEntry;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StSaveReq: begin
                if (bus.rst_sv) begin
                    state_d  = StEntry;
                    numero_d = '0;
                    cuenta_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = StEntry;
                    error_d = 1'b1;
                end else begin
                    guardar_d = 1'b1;
                    timer_d   = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StEntry;
            end
        endcase

        ocupado_d = (state_d == StSumReq) || (state_d == StWaitEnt) || (state_d == StSaveReq);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StEntry;
            numero_q  <= '0;
            cuenta_q  <= '0;
            timer_q   <= '0;
            suma_q    <= 1'b0;
            guardar_q <= 1'b0;
            ocupado_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            numero_q  <= numero_d;
            cuenta_q  <= cuenta_d;
            timer_q   <= timer_d;
            suma_q    <= suma_d;
            guardar_q <= guardar_d;
            ocupado_q <= ocupado_d;
            error_q   <= error_d;
        end
    end

    assign bus.numero  = numero_q;
    assign bus.cuenta  = cuenta_q;
    assign bus.suma    = suma_q;
    assign bus.guardar = guardar_q;
    assign bus.ocupado = ocupado_q;
    assign bus.error   = error_q;

endmodule

// File: tb/tb_captura_numero.sv
// Bench for captura_numero: table of entry-phase keys, directed multi-cycle
// sequences (sum, stale ent, save, timeout, reset) and a random key stream
// checked against a digit-queue model of the operand.
module tb_captura_numero;

    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    captura_numero_if #(.DIGITS(4)) bus ();

    captura_numero #(
        .DIGITS  (4),
        .KEY_SUM (4'hA),
        .KEY_SAVE(4'hB),
        .KEY_CLR (4'hC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    int tests = 0;
    int fails = 0;
    int suma_cnt = 0;
    int overlap_cnt = 0;

    // Model of the operand: typed digits, oldest first.
    logic [3:0] dig[$];
    logic       m_err;

    typedef struct {
        logic [3:0]  key;
        logic [15:0] num;
        logic [2:0]  cnt;
        logic        sum;
    } vec_t;

    vec_t vecs[12];

    // Count suma pulses and any cycle with suma and guardar together.
    always @(negedge clk) begin
        if (bus.suma) suma_cnt++;
        if (bus.suma && bus.guardar) overlap_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.tecla_valid = 1'b1;
        bus.tecla       = k;
        @(posedge clk);
        #1;
        bus.tecla_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (bus.ocupado && n < max) begin
            step();
            n++;
        end
    endtask

    function automatic logic [15:0] model_num();
        logic [15:0] v = '0;
        foreach (dig[i]) v = {v[11:0], dig[i]};
        return v;
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, " numero"}, 32'(bus.numero), 32'(model_num()));
        chk({tag, " cuenta"}, 32'(bus.cuenta), 32'(dig.size()));
        chk({tag, " error"}, 32'(bus.error), 32'(m_err));
        chk({tag, " ocupado"}, 32'(bus.ocupado), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        logic [3:0] k;

        bus.tecla_valid = 1'b1;
        bus.tecla       = 4'h3;
        bus.ent         = 1'b0;
        bus.rst_sv      = 1'b0;

        // T1: reset held two cycles with a pending strobe
        rst_n = 1'b0;
        step();
        step();
        bus.tecla_valid = 1'b0;
        chk("reset numero", 32'(bus.numero), 32'd0);
        chk("reset cuenta", 32'(bus.cuenta), 32'd0);
        chk("reset flags", {27'd0, bus.suma, bus.guardar, bus.ocupado, bus.error, 1'b0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T2 and key decoding: table of entry-phase keys
        vecs[0]  = '{4'h1, 16'h0001, 3'd1, 1'b0};
        vecs[1]  = '{4'h2, 16'h0012, 3'd2, 1'b0};
        vecs[2]  = '{4'h3, 16'h0123, 3'd3, 1'b0};
        vecs[3]  = '{4'h4, 16'h1234, 3'd4, 1'b0};
        vecs[4]  = '{4'h5, 16'h1234, 3'd4, 1'b0};
        vecs[5]  = '{4'hE, 16'h1234, 3'd4, 1'b0};
        vecs[6]  = '{4'hC, 16'h0000, 3'd0, 1'b0};
        vecs[7]  = '{4'hA, 16'h0000, 3'd0, 1'b0};
        vecs[8]  = '{4'h9, 16'h0009, 3'd1, 1'b0};
        vecs[9]  = '{4'h0, 16'h0090, 3'd2, 1'b0};
        vecs[10] = '{4'hF, 16'h0090, 3'd2, 1'b0};
        vecs[11] = '{4'hD, 16'h0090, 3'd2, 1'b0};
        foreach (vecs[i]) begin
            press(vecs[i].key);
            chk($sformatf("vec%0d numero", i), 32'(bus.numero), 32'(vecs[i].num));
            chk($sformatf("vec%0d cuenta", i), 32'(bus.cuenta), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d suma/ocupado", i), {30'd0, bus.suma, bus.ocupado},
                {30'd0, vecs[i].sum, 1'b0});
        end
        press(4'hC);

        // T3: sum with ent arriving two cycles after suma
        press(4'h4);
        press(4'h2);
        chk("t3 numero", 32'(bus.numero), 32'h42);
        s0 = suma_cnt;
        press(4'hA);
        chk("t3 suma", {30'd0, bus.suma, bus.ocupado}, 32'b11);
        step();
        chk("t3 suma drop", {30'd0, bus.suma, bus.ocupado}, 32'b01);
        @(negedge clk);
        bus.ent = 1'b1;
        step();
        wait_idle(5, n);
        chk("t3 result idle", 32'(bus.ocupado), 32'd0);
        chk("t3 result numero", {13'd0, bus.cuenta, bus.numero}, 32'd0);
        chk("t3 suma count", 32'(suma_cnt - s0), 32'd1);

        // T4: stale ent already high when the sum is requested
        press(4'h1);
        s0 = suma_cnt;
        press(4'hA);
        chk("t4 suma", 32'(bus.suma), 32'd1);
        step();
        chk("t4 wait after suma", {30'd0, bus.suma, bus.ocupado}, 32'b01);
        wait_idle(5, n);
        chk("t4 result idle", 32'(bus.ocupado), 32'd0);
        chk("t4 result numero", {13'd0, bus.cuenta, bus.numero}, 32'd0);
        chk("t4 single suma", 32'(suma_cnt - s0), 32'd1);
        @(negedge clk);
        bus.ent = 1'b0;

        // T5: save held until rst_sv, keys ignored meanwhile
        press(4'h7);
        press(4'hB);
        chk("t5 guardar", {30'd0, bus.guardar, bus.ocupado}, 32'b11);
        press(4'h5);
        chk("t5 held 1", {29'd0, bus.guardar, bus.cuenta[1:0]}, 32'b101);
        press(4'hC);
        chk("t5 held 2", {16'd0, bus.numero}, 32'h7);
        @(negedge clk);
        bus.rst_sv = 1'b1;
        step();
        bus.rst_sv = 1'b0;
        chk("t5 guardar drop", {30'd0, bus.guardar, bus.ocupado}, 32'd0);
        chk("t5 cleared", {13'd0, bus.cuenta, bus.numero}, 32'd0);

        // T6: timeout waiting for ent, clear, then reset inside WAIT_ENT
        press(4'h3);
        press(4'hA);
        n = 0;
        while (!bus.error && n < 40) begin
            step();
            n++;
        end
        chk("t6 timeout seen", 32'(bus.error), 32'd1);
        chk("t6 timeout window", 32'((n >= TIMEOUT) && (n <= TIMEOUT + 1)), 32'd1);
        chk("t6 operand kept", {13'd0, bus.cuenta, bus.numero}, {13'd0, 3'd1, 16'h3});
        chk("t6 idle", 32'(bus.ocupado), 32'd0);
        press(4'hC);
        chk("t6 clr error", {15'd0, bus.error, bus.numero}, 32'd0);
        press(4'h8);
        s0 = suma_cnt;
        press(4'hA);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b0;
        step();
        chk("t6 reset numero", {13'd0, bus.cuenta, bus.numero}, 32'd0);
        chk("t6 reset flags", {28'd0, bus.suma, bus.guardar, bus.ocupado, bus.error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t6 no extra suma", 32'(suma_cnt - s0), 32'd1);

        // Random key stream against the digit-queue model
        dig.delete();
        m_err = 1'b0;
        for (int it = 0; it < 250; it++) begin
            k = 4'($urandom_range(0, 15));
            press(k);
            if (k <= 4'd9) begin
                if (dig.size() < 4) dig.push_back(k);
                chk_model("rnd digit");
            end else if (k == 4'hC) begin
                dig.delete();
                m_err = 1'b0;
                chk_model("rnd clr");
            end else if (k == 4'hA && dig.size() > 0) begin
                chk("rnd suma", {30'd0, bus.suma, bus.ocupado}, 32'b11);
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    bus.tecla_valid = 1'($urandom_range(0, 1));
                    bus.tecla       = 4'($urandom_range(0, 15));
                    step();
                end
                @(negedge clk);
                bus.tecla_valid = 1'b0;
                bus.ent         = 1'b1;
                step();
                wait_idle(4, n);
                @(negedge clk);
                bus.ent = 1'b0;
                dig.delete();
                chk_model("rnd result");
            end else if (k == 4'hB) begin
                chk("rnd guardar", {30'd0, bus.guardar, bus.ocupado}, 32'b11);
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    bus.tecla_valid = 1'($urandom_range(0, 1));
                    bus.tecla       = 4'($urandom_range(0, 15));
                    step();
                end
                @(negedge clk);
                bus.tecla_valid = 1'b0;
                bus.rst_sv      = 1'b1;
                step();
                bus.rst_sv = 1'b0;
                chk("rnd guardar drop", 32'(bus.guardar), 32'd0);
                dig.delete();
                chk_model("rnd save");
            end else begin
                chk("rnd ignored suma", 32'(bus.suma), 32'd0);
                chk_model("rnd ignored");
            end
        end

        chk("suma/guardar overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
